// File: rtl/tone_decoder.sv
// Classifies a square-wave tone by measured half-period and reports the start, end and length in ms of each burst.
// Latency: an edge pulse comes 3 cycles after an audio_in transition, and the registered outputs follow 1 cycle later.
// Backpressure: none; levels and single-cycle pulses only, so the consumer must sample every cycle.
module tone_decoder #(
   parameter int unsigned CLOCK_HZ      = 100_000_000,
   parameter int unsigned ITEM0_FREQ_HZ = 800,
   parameter int unsigned ITEM1_FREQ_HZ = 1000,
   parameter int unsigned ITEM2_FREQ_HZ = 1200,
   parameter int unsigned ITEM3_FREQ_HZ = 1400,
   parameter int unsigned ERROR_FREQ_HZ = 300,
   parameter int unsigned TOL_PCT       = 5,
   parameter int unsigned LOCK_COUNT    = 4,
   parameter int unsigned SILENCE_MS    = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        audio_in,
   output logic        tone_detected,
   output logic [2:0]  tone_code,
   output logic        tone_start,
   output logic        tone_end,
   output logic [15:0] duration_ms,
   output logic        burst_err
);

   // expected half-periods (+1 matches the edge-to-edge cycle count) and tolerance windows
   localparam logic [31:0] HALF0 = 32'(CLOCK_HZ / (2 * ITEM0_FREQ_HZ) + 1);
   localparam logic [31:0] HALF1 = 32'(CLOCK_HZ / (2 * ITEM1_FREQ_HZ) + 1);
   localparam logic [31:0] HALF2 = 32'(CLOCK_HZ / (2 * ITEM2_FREQ_HZ) + 1);
   localparam logic [31:0] HALF3 = 32'(CLOCK_HZ / (2 * ITEM3_FREQ_HZ) + 1);
   localparam logic [31:0] HALF4 = 32'(CLOCK_HZ / (2 * ERROR_FREQ_HZ) + 1);
   localparam logic [31:0] WIN0  = 32'(HALF0 * TOL_PCT / 100);
   localparam logic [31:0] WIN1  = 32'(HALF1 * TOL_PCT / 100);
   localparam logic [31:0] WIN2  = 32'(HALF2 * TOL_PCT / 100);
   localparam logic [31:0] WIN3  = 32'(HALF3 * TOL_PCT / 100);
   localparam logic [31:0] WIN4  = 32'(HALF4 * TOL_PCT / 100);

   localparam logic [31:0] MS_LAST     = 32'(CLOCK_HZ / 1000 - 1);
   localparam logic [31:0] SILENCE_CYC = 32'((CLOCK_HZ / 1000) * SILENCE_MS);
   localparam logic [7:0]  LOCK_N      = 8'(LOCK_COUNT);
   localparam logic [2:0]  CODE_NONE   = 3'd7;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACQ    = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;

   logic        r_sync1, r_sync2, r_sync3, r_edge;
   logic [31:0] r_hp_cnt;
   logic [1:0]  r_state;
   logic [2:0]  r_cand;
   logic [7:0]  r_match;
   logic [2:0]  r_code;
   logic        r_det, r_start, r_end, r_berr;
   logic [15:0] r_dur;
   logic [31:0] r_ms_pre;
   logic [15:0] r_ms_run;
   logic [15:0] r_last_ms;

   logic [2:0]  w_class;
   logic [7:0]  w_next_match;
   logic        w_silence;
   logic        w_switch;
   logic        w_ms_clear;

   // true when p lies within h +/- w; 33-bit math keeps a saturated p from wrapping
   function automatic logic in_win(input logic [31:0] p, input logic [31:0] h, input logic [31:0] w);
      logic [32:0] pe, he, we;
      pe = {1'b0, p};
      he = {1'b0, h};
      we = {1'b0, w};
      return ((pe + we) >= he) && (pe <= (he + we));
   endfunction

   // synchronise audio_in and register a one-cycle pulse on either edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
         r_edge  <= 1'b0;
      end else begin
         r_sync1 <= audio_in;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         r_edge  <= r_sync2 ^ r_sync3;
      end
   end

   // cycles since the last edge pulse; equals the half-period on the cycle of the next edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hp_cnt <= 32'd0;
      end else if (r_edge) begin
         r_hp_cnt <= 32'd1;
      end else if (r_hp_cnt != 32'hFFFF_FFFF) begin
         r_hp_cnt <= r_hp_cnt + 32'd1;
      end
   end

   // classify the current half-period; the lowest matching code wins
   always_comb begin
      w_class = CODE_NONE;
      if (in_win(r_hp_cnt, HALF0, WIN0)) begin
         w_class = 3'd0;
      end else if (in_win(r_hp_cnt, HALF1, WIN1)) begin
         w_class = 3'd1;
      end else if (in_win(r_hp_cnt, HALF2, WIN2)) begin
         w_class = 3'd2;
      end else if (in_win(r_hp_cnt, HALF3, WIN3)) begin
         w_class = 3'd3;
      end else if (in_win(r_hp_cnt, HALF4, WIN4)) begin
         w_class = 3'd4;
      end
   end

   assign w_next_match = (w_class == r_cand) ? (r_match + 8'd1) : 8'd1;
   assign w_silence    = (r_hp_cnt >= SILENCE_CYC);
   assign w_switch     = (r_state == S_LOCKED) && r_edge && (w_class != CODE_NONE) &&
                         (w_class != r_code) && (w_next_match == LOCK_N);
   assign w_ms_clear   = (r_state == S_IDLE) || w_switch;

   // ms prescaler/run counter, restarted while idle and at a tone switch; each edge snapshots it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ms_pre  <= 32'd0;
         r_ms_run  <= 16'd0;
         r_last_ms <= 16'd0;
      end else begin
         if (w_ms_clear) begin
            r_ms_pre <= 32'd0;
            r_ms_run <= 16'd0;
         end else if (r_ms_pre == MS_LAST) begin
            r_ms_pre <= 32'd0;
            if (r_ms_run != 16'hFFFF) begin
               r_ms_run <= r_ms_run + 16'd1;
            end
         end else begin
            r_ms_pre <= r_ms_pre + 32'd1;
         end
         if (r_edge) begin
            r_last_ms <= w_ms_clear ? 16'd0 : r_ms_run;
         end
      end
   end

   // burst FSM: acquire a lock, track tone switches, and end bursts on silence
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cand  <= CODE_NONE;
         r_match <= 8'd0;
         r_code  <= CODE_NONE;
         r_det   <= 1'b0;
         r_start <= 1'b0;
         r_end   <= 1'b0;
         r_berr  <= 1'b0;
         r_dur   <= 16'd0;
      end else begin
         r_start <= 1'b0;
         r_end   <= 1'b0;
         r_berr  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cand  <= CODE_NONE;
               r_match <= 8'd0;
               if (r_edge) begin
                  r_state <= S_ACQ;
               end
            end
            S_ACQ: begin
               if (r_edge) begin
                  if (w_class == CODE_NONE) begin
                     r_cand  <= CODE_NONE;
                     r_match <= 8'd0;
                  end else if (w_next_match == LOCK_N) begin
                     r_state <= S_LOCKED;
                     r_code  <= w_class;
                     r_det   <= 1'b1;
                     r_start <= 1'b1;
                     r_cand  <= CODE_NONE;
                     r_match <= 8'd0;
                  end else begin
                     r_cand  <= w_class;
                     r_match <= w_next_match;
                  end
               end else if (w_silence) begin
                  r_state <= S_IDLE;
                  r_berr  <= 1'b1;
               end
            end
            S_LOCKED: begin
               if (r_edge) begin
                  // unclassifiable edges (including a short final edge) leave the lock alone
                  if (w_class != CODE_NONE) begin
                     if (w_class == r_code) begin
                        r_cand  <= CODE_NONE;
                        r_match <= 8'd0;
                     end else if (w_next_match == LOCK_N) begin
                        r_code  <= w_class;
                        r_start <= 1'b1;
                        r_end   <= 1'b1;
                        r_dur   <= r_last_ms;
                        r_cand  <= CODE_NONE;
                        r_match <= 8'd0;
                     end else begin
                        r_cand  <= w_class;
                        r_match <= w_next_match;
                     end
                  end
               end else if (w_silence) begin
                  r_state <= S_IDLE;
                  r_end   <= 1'b1;
                  r_dur   <= r_last_ms;
                  r_det   <= 1'b0;
                  r_code  <= CODE_NONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign tone_detected = r_det;
   assign tone_code     = r_code;
   assign tone_start    = r_start;
   assign tone_end      = r_end;
   assign duration_ms   = r_dur;
   assign burst_err     = r_berr;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder at CLOCK_HZ = 1 MHz (H = 626/501/417/358/1667, silence = 5000 cycles).
// A toggle launched just after posedge T gives its output pulse at T+4; silence ends a burst at last toggle + 5004.
// Bursts are shortened from the nominal lengths to keep the run well under 100k cycles.
module tb_tone_decoder;

   logic        clk;
   logic        rst;
   logic        audio_in;
   logic        tone_detected;
   logic [2:0]  tone_code;
   logic        tone_start;
   logic        tone_end;
   logic [15:0] duration_ms;
   logic        burst_err;

   tone_decoder #(.CLOCK_HZ(1_000_000)) dut (
      .clk           (clk),
      .rst           (rst),
      .audio_in      (audio_in),
      .tone_detected (tone_detected),
      .tone_code     (tone_code),
      .tone_start    (tone_start),
      .tone_end      (tone_end),
      .duration_ms   (duration_ms),
      .burst_err     (burst_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // pulse recorder: counts and timestamps every output pulse
   int          n_start = 0, n_end = 0, n_berr = 0;
   int          start_cyc = -1, end_cyc = -1, berr_cyc = -1;
   logic [2:0]  start_code = 3'd0;
   logic [15:0] end_dur = 16'd0;
   always @(negedge clk) begin
      if (tone_start) begin
         n_start++;
         start_cyc  = cyc;
         start_code = tone_code;
      end
      if (tone_end) begin
         n_end++;
         end_cyc = cyc;
         end_dur = duration_ms;
      end
      if (burst_err) begin
         n_berr++;
         berr_cyc = cyc;
      end
   end

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int t_first, t_last, t_exp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // n toggles, each preceded by a wait of 'half' cycles
   task automatic tone(input int half, input int n);
      for (int i = 0; i < n; i++) begin
         repeat (half) @(posedge clk);
         #1;
         audio_in = ~audio_in;
         if (i == 0) t_first = cyc;
         t_last = cyc;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      audio_in = 1'b0;
      idle(3);
      check("rst_code",     32'(tone_code),     32'd7);
      check("rst_detected", 32'(tone_detected), 32'd0);
      check("rst_start",    32'(tone_start),    32'd0);
      check("rst_end",      32'(tone_end),      32'd0);
      check("rst_berr",     32'(burst_err),     32'd0);
      check("rst_duration", 32'(duration_ms),   32'd0);
      rst = 1'b0;
      idle(5);

      // reset mid-tone: lock on item 1, then reset with audio low
      tone(501, 6);
      idle(20);
      check("pre_rst_start_cyc", start_cyc, t_first + 4*501 + 4);
      check("pre_rst_detected",  32'(tone_detected), 32'd1);
      check("pre_rst_code",      32'(tone_code),     32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_code",     32'(tone_code),     32'd7);
      check("mid_rst_detected", 32'(tone_detected), 32'd0);
      check("mid_rst_end",      32'(tone_end),      32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(5010);
      check("post_rst_no_end",  n_end,  0);
      check("post_rst_no_berr", n_berr, 0);

      // item 1, about 7.5 ms: last toggle 7515 cycles after first -> 7 ms
      tone(501, 16);
      check("item1_start_cyc",  start_cyc, t_first + 4*501 + 4);
      check("item1_start_code", 32'(start_code), 32'd1);
      idle(5010);
      check("item1_end_cyc",    end_cyc, t_last + 5004);
      check("item1_dur_range",  32'((end_dur == 16'd7) || (end_dur == 16'd8)), 32'd1);
      check("item1_idle_code",  32'(tone_code),     32'd7);
      check("item1_idle_det",   32'(tone_detected), 32'd0);
      check("item1_counts",     n_start*10 + n_end, 2*10 + 1);

      // error tone, held through one extra edge after lock
      tone(1667, 5);
      t_exp = t_first + 4*1667 + 4;
      idle(10);
      check("err_start_cyc",  start_cyc, t_exp);
      check("err_code",       32'(tone_code),     32'd4);
      check("err_detected_a", 32'(tone_detected), 32'd1);
      tone(1667, 1);
      idle(10);
      check("err_detected_b", 32'(tone_detected), 32'd1);
      idle(5010);
      check("err_end_cyc",    end_cyc, t_last + 5004);
      check("err_idle_det",   32'(tone_detected), 32'd0);

      // tolerance edge inside item 1 window
      tone(476, 10);
      check("tol476_start_cyc",  start_cyc, t_first + 4*476 + 4);
      check("tol476_start_code", 32'(start_code), 32'd1);
      idle(5010);
      check("tol476_end_count",  n_end, 3);

      // just outside the window: never locks, one burst error at silence
      tone(475, 10);
      idle(5010);
      check("tol475_no_start", n_start, 4);
      check("tol475_berr_cnt", n_berr,  1);
      check("tol475_berr_cyc", berr_cyc, t_last + 5004);

      // tone switch item 0 -> item 3 on the 4th matching 358 edge
      tone(626, 6);
      check("sw_lock0_code", 32'(start_code), 32'd0);
      tone(358, 8);
      t_exp = t_first + 3*358 + 4;
      check("sw_start_cyc",  start_cyc, t_exp);
      check("sw_end_cyc",    end_cyc,   t_exp);
      check("sw_code",       32'(tone_code), 32'd3);
      check("sw_counts",     n_start*10 + n_end, 6*10 + 4);
      idle(5010);
      check("sw_final_end",  n_end, 5);

      // short final edge: ignored while locked, but its time sets the duration (4038 cycles -> 4 ms)
      tone(358, 12);
      check("short_start_code", 32'(start_code), 32'd3);
      tone(100, 1);
      idle(50);
      check("short_still_det",  32'(tone_detected), 32'd1);
      check("short_still_code", 32'(tone_code),     32'd3);
      idle(5010);
      check("short_end_cyc",    end_cyc, t_last + 5004);
      check("short_duration",   32'(end_dur), 32'd4);
      check("short_counts",     n_start*10 + n_end, 7*10 + 6);
      check("total_berr",       n_berr, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tone_decoder.md
# tone_decoder

Square-wave tone detector and classifier for the vending feedback audio path. It samples a single-bit audio line, which is normally the vend-feedback tone generator output looped back for self-test. It measures the half-period between edges and classifies each burst as one of four item tones or the error tone. It reports each burst's start, end and duration in milliseconds.

## Interface
- CLOCK_HZ, 100_000_000, system clock frequency
- ITEM0_FREQ_HZ / ITEM1_FREQ_HZ / ITEM2_FREQ_HZ / ITEM3_FREQ_HZ, 800 / 1000 / 1200 / 1400, item tone frequencies (codes 0–3)
- ERROR_FREQ_HZ, 300, error tone frequency (code 4)
- TOL_PCT, 5, classification tolerance in percent of expected half-period
- LOCK_COUNT, 4, consecutive matching half-periods required to lock
- SILENCE_MS, 5, edge-free time that ends a burst
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- audio_in  in  1  asynchronous square-wave input
- tone_detected  out  1  high while locked on a tone
- tone_code  out  3  0–3 item, 4 error, 7 none
- tone_start  out  1  one-cycle pulse on lock
- tone_end  out  1  one-cycle pulse when a locked tone ends
- duration_ms  out  16  length of the last ended tone, valid from tone_end onward
- burst_err  out  1  one-cycle pulse when a burst ends without ever locking

## Operation
- audio_in passes through a 2-FF synchronizer. Both rising and falling edges of the synchronized signal produce an edge pulse.
- Measured half-period P is the cycle distance between consecutive edge pulses.
- The half-period counter is 32-bit and saturates at its maximum value.
- Expected half-period H_k = CLOCK_HZ/(2·F_k) + 1, using integer division. Window W_k = H_k·TOL_PCT/100, using integer division. Both are constants computed at elaboration.
- P classifies as code k if |P − H_k| ≤ W_k. Otherwise P classifies as none. If two windows match, the lowest code wins.
- State IDLE:
  - On an edge, go to ACQ.
  - Clear cand to none and match to 0.
  - Clear the ms prescaler and the ms run counter.
- State ACQ, on each edge, classify P:
  - If P is none, set cand = none and match = 0.
  - If P equals cand, increment match.
  - If P differs from cand, set cand = class and match = 1.
  - When match reaches LOCK_COUNT, go to LOCKED. Set tone_code = cand, set tone_detected = 1, and pulse tone_start.
- State LOCKED, on each edge:
  - Classes equal to tone_code reset the alternate-code counter.
  - A valid class c' ≠ tone_code counts alternate matches using the same rules as ACQ.
  - When the alternate count reaches LOCK_COUNT, switch tones in one cycle. Pulse tone_end and tone_start together. duration_ms = last_edge_ms. tone_code = c'. The ms counters restart at this edge.
  - Edges classified as none are ignored. The forced final edge of a burst is short and falls into this case.
- Duration tracking:
  - The ms run counter increments every CLOCK_HZ/1000 cycles. It is 16-bit and saturates.
  - Every edge snapshots the ms run counter into last_edge_ms.
- Silence: in ACQ or LOCKED, if SILENCE_CYCLES = (CLOCK_HZ/1000)·SILENCE_MS cycles pass since the last edge, go to IDLE.
  - From LOCKED: pulse tone_end, duration_ms = last_edge_ms, tone_detected = 0, tone_code = 7.
  - From ACQ: pulse burst_err.
- Reset values: tone_detected 0, tone_code 7, tone_start 0, tone_end 0, burst_err 0, duration_ms 0. State is IDLE and all counters are 0.
- Reset mid-tone clears everything immediately. No tone_end or burst_err is emitted.

## Timing
- Edge pulse E occurs 3 cycles after an audio_in transition: 2 cycles of sync plus 1 cycle of edge register.
- All outputs are registered and update at cycle E+1 for the edge that triggers them.
- Lock occurs on the (LOCK_COUNT+1)-th edge of a clean burst, because the first edge only starts measurement.
- The silence timeout fires exactly SILENCE_CYCLES after the last edge pulse. The output updates the following cycle.
- duration_ms holds its value until the next tone_end.

## Test plan
Bench parameters: CLOCK_HZ=1_000_000, defaults otherwise. This gives H = 626 / 501 / 417 / 358 for items 0–3, H = 1667 for error, and SILENCE_CYCLES = 5000.
- Reset: assert rst mid-stream -> tone_code = 7 and all pulses 0 immediately, with no tone_end afterwards.
- Item 1 tone: half-period 501 for 150 ms, then hold low -> tone_start with code 1 at the 5th edge + 4 cycles; tone_end 5001 cycles after the last edge pulse; duration_ms ∈ {149, 150}.
- Error tone: half-period 1667 for 150 ms -> tone_start with code 4, tone_detected high throughout, tone_end at silence.
- Tolerance boundary, item 1 window ±25:
  - Half-period 476 -> locks to code 1.
  - Half-period 475 for 50 ms -> no tone_start; burst_err pulses once at silence.
- Tone switch: lock on 626 (code 0), then change to 358 -> tone_end and tone_start pulse in the same cycle at the 4th matching 358-edge; tone_code = 3.
- Short final edge: a locked burst ends with a 100-cycle half-period -> stays locked, and duration_ms counts up to that final edge.
